hall_period_meter: RTL and testbench



---
 rtl/unicycle_pkg.sv | 15 +
 rtl/sync_debounce.sv | 47 ++++
 rtl/hall_period_meter.sv | 109 ++++++++++
 tb/tb_hall_period_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/unicycle_pkg.sv
// Shared definitions for the unicycle wheel-speed path: measurement FSM states and
// default debounce/timeout constants, also consumed by the chaser's blink-delay table.
package unicycle_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
  localparam int DEFAULT_PERIOD_W        = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 50_000_000;

endpackage

// File: rtl/sync_debounce.sv
// Synchronises an asynchronous pin into clk and only lets the filtered level follow it
// after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module sync_debounce
  import unicycle_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       db_cnt;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // The increment that would bring the count to DEBOUNCE_CYCLES flips the level instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_out <= 1'b0;
      db_cnt    <= '0;
    end else if (sync_lvl == level_out) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      level_out <= sync_lvl;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hall_period_meter.sv
// Hall sensor front end: debounced revolution pulse, revolution period in clk cycles,
// and a stopped flag when no revolution arrives within TIMEOUT_CYCLES.
module hall_period_meter
  import unicycle_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PERIOD_W        = DEFAULT_PERIOD_W,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hall_in,
  output logic                rev_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stopped,
  output logic                state_dbg
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_P = PERIOD_W'(TIMEOUT_CYCLES);

  logic hall_lvl;
  logic hall_lvl_d;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] cnt, cnt_next;
  logic [PERIOD_W-1:0] period_next;
  logic                valid_next;
  logic                stopped_next;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (hall_in),
    .level_out(hall_lvl)
  );

  // Registered rising-edge detect; falling edges of the filtered level are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_lvl_d <= 1'b0;
      rev_pulse  <= 1'b0;
    end else begin
      hall_lvl_d <= hall_lvl;
      rev_pulse  <= hall_lvl & ~hall_lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stopped      <= 1'b1;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      period       <= period_next;
      period_valid <= valid_next;
      stopped      <= stopped_next;
    end
  end

  // A revolution edge always beats the timeout when both land on the same cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    period_next  = period;
    valid_next   = 1'b0;
    stopped_next = stopped;
    case (state)
      IDLE: begin
        stopped_next = 1'b1;
        cnt_next     = '0;
        if (rev_pulse) begin
          state_next = MEASURE;
          cnt_next   = PERIOD_W'(1);
        end
      end
      MEASURE: begin
        if (rev_pulse) begin
          period_next  = cnt;
          valid_next   = 1'b1;
          stopped_next = 1'b0;
          cnt_next     = PERIOD_W'(1);
        end else if (cnt == TIMEOUT_P) begin
          state_next   = IDLE;
          stopped_next = 1'b1;
          period_next  = '0;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + PERIOD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign state_dbg = (state == MEASURE);

endmodule

// File: tb/tb_hall_period_meter.sv
// Bench for hall_period_meter: directed scenarios plus random hall waveforms, all
// checked every cycle against a timestamp-based reference model.
module tb_hall_period_meter;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int PW   = 16;
  localparam int TMO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hall_in = 1'b0;
  logic          rev_pulse;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stopped;
  logic          state_dbg;

  hall_period_meter #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .PERIOD_W       (PW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hall_in     (hall_in),
    .rev_pulse   (rev_pulse),
    .period      (period),
    .period_valid(period_valid),
    .stopped     (stopped),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  bit sync_q[$];
  bit lvl;
  int run;
  bit rise_pending;
  bit exp_rev;
  bit exp_valid;
  int exp_period;
  bit exp_stopped;
  bit measuring;
  int last_pulse;

  // observations for directed checks
  int last_rev_cyc;
  int valid_cnt;
  int last_period;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pin delayed by the synchroniser, level follows after DEB agreeing samples,
  // pulse one cycle after a rise, period = distance between pulse timestamps.
  task automatic model_edge(input logic r, input logic h);
    bit d;
    bit prev_rev;
    if (r) begin
      sync_q.delete();
      for (int i = 0; i < SYNC; i++) sync_q.push_back(1'b0);
      lvl = 0; run = 0; rise_pending = 0; exp_rev = 0; exp_valid = 0;
      exp_period = 0; exp_stopped = 1; measuring = 0; last_pulse = 0;
    end else begin
      d = sync_q.pop_front();
      sync_q.push_back(h);
      prev_rev     = exp_rev;
      exp_rev      = rise_pending;
      rise_pending = 0;
      if (d != lvl) begin
        run++;
        if (run == DEB) begin
          lvl = d;
          run = 0;
          if (d) rise_pending = 1;
        end
      end else begin
        run = 0;
      end
      exp_valid = 0;
      if (prev_rev) begin
        if (measuring) begin
          exp_period  = (cyc - 1) - last_pulse;
          exp_valid   = 1;
          exp_stopped = 0;
        end
        measuring  = 1;
        last_pulse = cyc - 1;
      end else if (measuring && cyc == last_pulse + TMO + 1) begin
        measuring   = 0;
        exp_stopped = 1;
        exp_period  = 0;
      end
    end
  endtask

  // driver: one clock, then compare every output against the model
  task automatic step();
    logic r, h;
    r = rst;
    h = hall_in;
    @(posedge clk);
    cyc++;
    #1;
    model_edge(r, h);
    check("rev_pulse", {31'b0, rev_pulse}, {31'b0, exp_rev});
    check("period_valid", {31'b0, period_valid}, {31'b0, exp_valid});
    check("period", {16'b0, period}, exp_period);
    check("stopped", {31'b0, stopped}, {31'b0, exp_stopped});
    check("state", {31'b0, state_dbg}, {31'b0, measuring});
    if (rev_pulse === 1'b1) last_rev_cyc = cyc;
    if (period_valid === 1'b1) begin
      valid_cnt++;
      last_period = int'(period);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // one clean revolution: high for hi cycles, low for lo cycles
  task automatic rev(input int hi, input int lo);
    hall_in = 1'b1;
    run_cycles(hi);
    hall_in = 1'b0;
    run_cycles(lo);
  endtask

  initial begin
    int t0;
    int len;

    // reset with the pin toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hall_in = i[0];
      step();
    end
    rst = 1'b0;
    hall_in = 1'b0;
    step();
    check("rel_stopped", {31'b0, stopped}, 32'd1);
    check("rel_period", {16'b0, period}, 32'd0);
    run_cycles(10);

    // glitch rejection, then 5-cycle step latency
    hall_in = 1'b1;
    run_cycles(3);
    hall_in = 1'b0;
    last_rev_cyc = -1;
    run_cycles(15);
    check("glitch_no_pulse", last_rev_cyc, -1);
    check("glitch_idle", {31'b0, state_dbg}, 32'd0);
    t0 = cyc;
    hall_in = 1'b1;
    run_cycles(5);
    hall_in = 1'b0;
    run_cycles(15);
    check("latency", last_rev_cyc - t0, SYNC + DEB + 1);
    run_cycles(TMO + 10);

    // three edges 40 cycles apart
    valid_cnt = 0;
    for (int i = 0; i < 3; i++) rev(10, 30);
    run_cycles(10);
    check("p40_count", valid_cnt, 2);
    check("p40_period", last_period, 40);
    check("p40_stopped", {31'b0, stopped}, 32'd0);

    // no further edges: timeout
    run_cycles(TMO + 5);
    check("tmo_stopped", {31'b0, stopped}, 32'd1);
    check("tmo_period", {16'b0, period}, 32'd0);
    check("tmo_count", valid_cnt, 2);

    // edges exactly TIMEOUT apart: edge wins
    valid_cnt = 0;
    rev(10, TMO - 10);
    rev(10, TMO - 10);
    rev(10, 5);
    check("edge_tmo_count", valid_cnt, 2);
    check("edge_tmo_period", last_period, TMO);
    check("edge_tmo_state", {31'b0, state_dbg}, 32'd1);
    check("edge_tmo_stopped", {31'b0, stopped}, 32'd0);
    run_cycles(TMO + 10);

    // reset mid-measurement
    rev(10, 30);
    rev(10, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("mid_rst_state", {31'b0, state_dbg}, 32'd0);
    check("mid_rst_stopped", {31'b0, stopped}, 32'd1);
    valid_cnt = 0;
    rev(10, 20);
    check("mid_rst_first", valid_cnt, 0);
    rev(10, 10);
    check("mid_rst_count", valid_cnt, 1);
    check("mid_rst_period", last_period, 30);

    // random waveforms with glitches, timeouts and occasional resets
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        run_cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      hall_in = ~hall_in;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 5);
      else len = $urandom_range(5, 130);
      run_cycles(len);
    end
    run_cycles(TMO + 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
